fetch_sequencer: RTL

Instruction-fetch controller for the five-stage pipelined CPU. It owns the fetch PC, issues word requests to instruction memory over a req/ack handshake, and buffers one fetched instruction for the IF/ID register. It also applies branch and jump redirects from ID, computing branch targets with the sign-extended branch offset. Delay-slot or flush semantics are selected at compile time.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/branch_target_calc.sv | 28 ++
 rtl/fetch_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : cpu_pkg                                                   |
// | Purpose  : Shared constants and types for the five-stage CPU front   |
// |            end: reset fetch address, instruction width and the fetch |
// |            sequencer state encoding.                                 |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package cpu_pkg;

  // Instruction word width in bits
  localparam int unsigned INSTR_W = 32;

  // First fetch address after reset
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // reset state, no request
    S_REQ  = 2'd1,  // request may issue
    S_WAIT = 2'd2   // request outstanding, address held
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/branch_target_calc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : branch_target_calc                                        |
// | Purpose  : Combinational redirect target selection. Jumps use the    |
// |            word-aligned jump target; branches add the sign-extended, |
// |            word-scaled offset to PC+4 (32-bit wrap).                 |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module branch_target_calc (
  input  logic        jump_valid_i,
  input  logic [31:0] jump_target_i,
  input  logic [31:0] br_base_i,
  input  logic [15:0] br_imme_i,
  output logic [31:0] target_o
);

  logic [31:0] br_offset;
  logic [31:0] jump_aligned;

  // Offset is in words: sign-extend to 30 bits then shift left by two
  assign br_offset    = {{14{br_imme_i[15]}}, br_imme_i, 2'b00};
  // Low two bits of a jump target are never meaningful
  assign jump_aligned = jump_target_i & 32'hFFFF_FFFC;
  // A jump takes priority when both are reported in the same cycle
  assign target_o     = jump_valid_i ? jump_aligned : (br_base_i + br_offset);

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fetch_sequencer                                           |
// | Purpose  : Instruction-fetch controller. Owns the fetch PC, issues   |
// |            one word request at a time over req/ack, buffers one      |
// |            instruction for IF/ID and applies branch/jump redirects.  |
// | Config   : FETCH_DELAY_SLOT_EN defined   -> MIPS delay-slot redirect |
// |            FETCH_DELAY_SLOT_EN undefined -> flush-on-redirect        |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  output logic               imem_req_o,
  output logic [31:0]        imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               if_valid_o,
  output logic [INSTR_W-1:0] if_instr_o,
  output logic [31:0]        if_pc_o,
  input  logic               if_stall_i,
  input  logic               br_valid_i,
  input  logic [31:0]        br_base_i,
  input  logic [15:0]        br_imme_i,
  input  logic               jump_valid_i,
  input  logic [31:0]        jump_target_i,
  output logic               flush_o,
  output logic               redirect_o
);

  fetch_state_e       state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        req_addr_q, req_addr_d;
  logic               squash_q, squash_d;
  logic               buf_valid_q, buf_valid_d;
  logic [INSTR_W-1:0] buf_instr_q, buf_instr_d;
  logic [31:0]        buf_pc_q, buf_pc_d;
  logic               redirect_q;

  logic [31:0]        target;
  logic               req;
  logic [31:0]        addr;
  logic               ack;
  logic               ack_keep;
  logic               consume;
  logic               redirect;
  logic               squash_now;

  branch_target_calc u_target (
    .jump_valid_i  (jump_valid_i),
    .jump_target_i (jump_target_i),
    .br_base_i     (br_base_i),
    .br_imme_i     (br_imme_i),
    .target_o      (target)
  );

  // ID only takes the buffered word, or a redirect, in a non-stalled cycle
  assign consume  = buf_valid_q & ~if_stall_i;
  assign redirect = (br_valid_i | jump_valid_i) & ~if_stall_i;
  assign ack      = req & imem_ack_i;

`ifdef FETCH_DELAY_SLOT_EN
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        pend_valid_q, pend_valid_d;

  // Only a buffered delay slot makes the in-flight fetch wrong-path
  assign squash_now = redirect & buf_valid_q & req;
  assign flush_o    = 1'b0;
`else
  // Without a delay slot every in-flight fetch behind a redirect is dead
  assign squash_now = redirect & req;
  assign flush_o    = redirect;
`endif

  assign ack_keep = ack & ~squash_q & ~squash_now;

  // FSM next state plus request/address outputs
  always_comb begin
    state_d    = state_q;
    req        = 1'b0;
    addr       = fetch_pc_q;
    req_addr_d = req_addr_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        // Issue only if the buffer is guaranteed to have room at ack time
        req        = ~buf_valid_q | ~if_stall_i;
        req_addr_d = fetch_pc_q;
        if (req && !imem_ack_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        // Held address is independent of any redirect that moves fetch_pc
        req  = 1'b1;
        addr = req_addr_q;
        if (imem_ack_i) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Buffer load/drain and squash bookkeeping
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    squash_d    = squash_q;
    if (ack_keep) begin
      buf_valid_d = 1'b1;
      buf_instr_d = imem_rdata_i;
      buf_pc_d    = addr;
    end else if (consume) begin
      buf_valid_d = 1'b0;
    end
    if (ack) squash_d = 1'b0;
    else if (squash_now) squash_d = 1'b1;
  end

`ifdef FETCH_DELAY_SLOT_EN
  // Next fetch PC: sequential, pending target, or immediate redirect
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    pend_pc_d    = pend_pc_q;
    pend_valid_d = pend_valid_q;
    if (ack_keep) begin
      fetch_pc_d   = pend_valid_q ? pend_pc_q : addr + 32'd4;
      pend_valid_d = 1'b0;
    end
    if (redirect) begin
      if (buf_valid_q || ack_keep) begin
        // Delay slot is buffered or completes now: target is next fetch
        fetch_pc_d   = target;
        pend_valid_d = 1'b0;
      end else begin
        // Delay slot still to come: park target until its fetch completes
        pend_pc_d    = target;
        pend_valid_d = 1'b1;
      end
    end
  end

  // Pending-redirect registers
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pend_pc_q    <= RESET_PC;
      pend_valid_q <= 1'b0;
    end else begin
      pend_pc_q    <= pend_pc_d;
      pend_valid_q <= pend_valid_d;
    end
  end
`else
  // Next fetch PC: sequential, or redirect target which always wins
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (ack_keep) fetch_pc_d = addr + 32'd4;
    if (redirect) fetch_pc_d = target;
  end
`endif

  // State register and datapath registers; reset drops any outstanding request
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= RESET_PC;
      req_addr_q  <= RESET_PC;
      squash_q    <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
      redirect_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_addr_q  <= req_addr_d;
      squash_q    <= squash_d;
      buf_valid_q <= buf_valid_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      redirect_q  <= redirect;
    end
  end

  assign imem_req_o  = req;
  assign imem_addr_o = addr;
  assign if_valid_o  = buf_valid_q;
  assign if_instr_o  = buf_instr_q;
  assign if_pc_o     = buf_pc_q;
  assign redirect_o  = redirect_q;

endmodule
`default_nettype wire
